// File: rtl/bf16_sqrt_pkg.sv
// Shared types for the bfloat16 square-root path: operand classes, prep FSM
// states and the prepared-operand bundle handed to the sqrt core.
package bf16_sqrt_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 7;
    localparam int BIAS  = 127;

    typedef enum logic [2:0] {
        NORMAL = 3'd0,
        ZERO   = 3'd1,
        INF    = 3'd2,
        NAN    = 3'd3,
        NEG    = 3'd4
    } sqrt_class_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        HOLD = 2'd2
    } prep_state_e;

    typedef struct packed {
        sqrt_class_e        cls;
        logic               sign;
        logic [EXP_W-1:0]   exp;
        logic [MAN_W+1:0]   mant;
    } sqrt_op_t;

endpackage

// File: rtl/bf16_classify.sv
// Combinational bf16 operand classifier; flags positive subnormals that still
// need normalising before the square root.
module bf16_classify
    import bf16_sqrt_pkg::*;
#(
    parameter int EXP_W = bf16_sqrt_pkg::EXP_W,
    parameter int MAN_W = bf16_sqrt_pkg::MAN_W,
    parameter bit FTZ   = 1'b0
) (
    input  logic [EXP_W+MAN_W:0] data_i,
    output sqrt_class_e          cls_o,
    output logic                 subn_o
);

    logic             sign;
    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] man_f;
    logic             exp_max, exp_zero, man_zero;

    assign sign     = data_i[EXP_W+MAN_W];
    assign exp_f    = data_i[EXP_W+MAN_W-1:MAN_W];
    assign man_f    = data_i[MAN_W-1:0];
    assign exp_max  = &exp_f;
    assign exp_zero = ~|exp_f;
    assign man_zero = ~|man_f;

    // Priority order matters: -0 stays ZERO and -inf falls through to NEG.
    always_comb begin
        cls_o  = NORMAL;
        subn_o = 1'b0;
        if (exp_max && !man_zero) begin
            cls_o = NAN;
        end else if (exp_max && !sign) begin
            cls_o = INF;
        end else if (exp_zero && man_zero) begin
            cls_o = ZERO;
        end else if (sign) begin
            cls_o = NEG;
        end else if (exp_zero) begin
            if (FTZ) begin
                cls_o = ZERO;
            end else begin
                subn_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bf16_sqrt_prep.sv
// bf16 square-root operand preparation: classify, normalise subnormals, make
// the exponent even and emit the halved biased exponent with a 2.7 significand.
module bf16_sqrt_prep
    import bf16_sqrt_pkg::*;
#(
    parameter int EXP_W = bf16_sqrt_pkg::EXP_W,
    parameter int MAN_W = bf16_sqrt_pkg::MAN_W,
    parameter int BIAS  = bf16_sqrt_pkg::BIAS,
    parameter bit FTZ   = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2:0]           out_class,
    output logic                 out_sign,
    output logic [EXP_W-1:0]     out_exp,
    output logic [MAN_W+1:0]     out_mant,
    output logic                 error
);

    localparam logic signed [9:0] BIAS_S = 10'(BIAS);
    localparam logic signed [9:0] E_SUB  = 10'(1 - BIAS);

    prep_state_e              state_q, state_d;
    logic        [MAN_W:0]    w_q, w_d, w_sh;
    logic signed [9:0]        e_q, e_d, e_dec, e_in;
    sqrt_op_t                 op_q, op_d;
    sqrt_class_e              cls_c;
    logic                     subn_c;
    logic                     accept;

    bf16_classify #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W),
        .FTZ   (FTZ)
    ) u_classify (
        .data_i (in_data),
        .cls_o  (cls_c),
        .subn_o (subn_c)
    );

    // An odd exponent moves one factor of two into the significand so the
    // exponent halves exactly; the significand then spans [1,4).
    function automatic sqrt_op_t pack_normal(input logic [MAN_W:0] w,
                                             input logic signed [9:0] e);
        sqrt_op_t          op;
        logic signed [9:0] ee;
        logic signed [9:0] biased;
        op.cls  = NORMAL;
        op.sign = 1'b0;
        if (e[0]) begin
            op.mant = {w, 1'b0};
            ee      = e - 10'sd1;
        end else begin
            op.mant = {1'b0, w};
            ee      = e;
        end
        biased = (ee >>> 1) + BIAS_S;
        op.exp = biased[EXP_W-1:0];
        return op;
    endfunction

    assign in_ready  = !rst && ((state_q == IDLE) || ((state_q == HOLD) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == HOLD);
    assign error     = out_valid && (op_q.cls == NEG);
    assign out_class = op_q.cls;
    assign out_sign  = op_q.sign;
    assign out_exp   = op_q.exp;
    assign out_mant  = op_q.mant;

    assign w_sh  = {w_q[MAN_W-1:0], 1'b0};
    assign e_dec = e_q - 10'sd1;
    assign e_in  = $signed(10'(in_data[EXP_W+MAN_W-1:MAN_W])) - BIAS_S;

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        e_d     = e_q;
        op_d    = op_q;
        unique case (state_q)
            IDLE, HOLD: begin
                if (accept) begin
                    if (subn_c) begin
                        w_d     = {1'b0, in_data[MAN_W-1:0]};
                        e_d     = E_SUB;
                        state_d = NORM;
                    end else begin
                        state_d = HOLD;
                        if (cls_c == NORMAL) begin
                            op_d = pack_normal({1'b1, in_data[MAN_W-1:0]}, e_in);
                        end else begin
                            op_d.cls  = cls_c;
                            op_d.sign = (cls_c == ZERO) ? in_data[EXP_W+MAN_W] : 1'b0;
                            op_d.exp  = '0;
                            op_d.mant = '0;
                        end
                    end
                end else if (state_q == HOLD && out_ready) begin
                    state_d = IDLE;
                end
            end
            NORM: begin
                w_d = w_sh;
                e_d = e_dec;
                if (w_sh[MAN_W]) begin
                    op_d    = pack_normal(w_sh, e_dec);
                    state_d = HOLD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            w_q     <= '0;
            e_q     <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            e_q     <= e_d;
            op_q    <= op_d;
        end
    end

endmodule

// File: tb/tb_bf16_sqrt_prep.sv
// Directed bench for bf16_sqrt_prep: normals, subnormals, specials,
// back-pressure and asynchronous reset.
module tb_bf16_sqrt_prep;
    import bf16_sqrt_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_class;
    logic        out_sign;
    logic [7:0]  out_exp;
    logic [8:0]  out_mant;
    logic        error;

    int errors = 0;
    int checks = 0;

    bf16_sqrt_prep dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_sign  (out_sign),
        .out_exp   (out_exp),
        .out_mant  (out_mant),
        .error     (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge where the
    // result is visible, after checking latency and all output fields.
    task automatic op(input string tag, input logic [15:0] d, input int lat,
                      input logic [2:0] cls, input logic sgn, input logic [7:0] ex,
                      input logic [8:0] mn, input logic err);
        int n;
        chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1 in_valid = 1'b0;
        in_data  = 16'hFFFF;
        @(negedge clk);
        n = 1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'(lat));
        chk({tag, " class"}, 32'(out_class), 32'(cls));
        chk({tag, " sign"}, 32'(out_sign), 32'(sgn));
        chk({tag, " exp"}, 32'(out_exp), 32'(ex));
        chk({tag, " mant"}, 32'(out_mant), 32'(mn));
        chk({tag, " error"}, 32'(error), 32'(err));
    endtask

    initial begin
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst error", 32'(error), 32'd0);
        chk("rst out_exp", 32'(out_exp), 32'd0);
        chk("rst out_mant", 32'(out_mant), 32'd0);
        chk("rst out_class", 32'(out_class), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle in_ready", 32'(in_ready), 32'd1);

        op("4.0",     16'h4080, 1, NORMAL, 1'b0, 8'h80, 9'h080, 1'b0); @(negedge clk);
        chk("drain out_valid", 32'(out_valid), 32'd0);
        op("8.0",     16'h4100, 1, NORMAL, 1'b0, 8'h80, 9'h100, 1'b0); @(negedge clk);
        op("1.0",     16'h3F80, 1, NORMAL, 1'b0, 8'h7F, 9'h080, 1'b0); @(negedge clk);
        op("minnorm", 16'h0080, 1, NORMAL, 1'b0, 8'h40, 9'h080, 1'b0); @(negedge clk);
        op("maxnorm", 16'h7F7F, 1, NORMAL, 1'b0, 8'hBE, 9'h1FE, 1'b0); @(negedge clk);
        op("sub0001", 16'h0001, 8, NORMAL, 1'b0, 8'h3C, 9'h100, 1'b0); @(negedge clk);
        op("sub0040", 16'h0040, 2, NORMAL, 1'b0, 8'h3F, 9'h100, 1'b0); @(negedge clk);
        op("neg",     16'hC080, 1, NEG,    1'b0, 8'h00, 9'h000, 1'b1); @(negedge clk);
        op("negzero", 16'h8000, 1, ZERO,   1'b1, 8'h00, 9'h000, 1'b0); @(negedge clk);
        op("poszero", 16'h0000, 1, ZERO,   1'b0, 8'h00, 9'h000, 1'b0); @(negedge clk);
        op("nan",     16'h7FC0, 1, NAN,    1'b0, 8'h00, 9'h000, 1'b0); @(negedge clk);
        op("inf",     16'h7F80, 1, INF,    1'b0, 8'h00, 9'h000, 1'b0); @(negedge clk);
        op("neginf",  16'hFF80, 1, NEG,    1'b0, 8'h00, 9'h000, 1'b1); @(negedge clk);

        // Back-pressure with a pending operand, then same-cycle hand-off.
        out_ready = 1'b0;
        op("stall", 16'h4080, 1, NORMAL, 1'b0, 8'h80, 9'h080, 1'b0);
        in_valid = 1'b1;
        in_data  = 16'h4100;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall out_valid", 32'(out_valid), 32'd1);
            chk("stall out_mant", 32'(out_mant), 32'h080);
            chk("stall in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1 chk("handoff in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("handoff out_valid", 32'(out_valid), 32'd1);
        chk("handoff out_mant", 32'(out_mant), 32'h100);
        chk("handoff out_exp", 32'(out_exp), 32'h80);
        @(negedge clk);
        chk("handoff drain", 32'(out_valid), 32'd0);

        // Reset while holding a result.
        out_ready = 1'b0;
        op("rsthold", 16'h4080, 1, NORMAL, 1'b0, 8'h80, 9'h080, 1'b0);
        #1 rst = 1'b1;
        #1 chk("rsthold out_valid", 32'(out_valid), 32'd0);
        chk("rsthold in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);

        // Reset in the middle of subnormal normalisation.
        chk("rstnorm in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = 16'h0001;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1 chk("rstnorm out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rstnorm idle in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("rstnorm stale output", 32'(seen), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
